// File: rtl/glitch_sched_pkg.sv
// rtl/glitch_sched_pkg.sv - shared types and constants for the glitch-clock scheduler
package glitch_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_DELAY = 3'd2,
    ST_PULSE = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // A programmed width/gap/count of zero behaves as this value.
  localparam int unsigned ZERO_SUB = 1;

endpackage

// File: rtl/glitch_sched_trig.sv
// rtl/glitch_sched_trig.sv - trigger synchroniser, mask, OR-reduce and rising-edge detect
module trig_sync_edge
  import glitch_sched_pkg::*;
#(
  parameter int N_TRIG = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_TRIG-1:0] trig,
  input  logic [N_TRIG-1:0] mask,
  output logic              rise
);

  logic [N_TRIG-1:0] meta;
  logic [N_TRIG-1:0] sync;
  logic              any;
  logic              prev;

  // prev always tracks the masked level, so a level held across arm never fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      sync <= '0;
      prev <= 1'b0;
    end else begin
      meta <= trig;
      sync <= meta;
      prev <= any;
    end
  end

  assign any  = |(sync & mask);
  assign rise = any & ~prev;

endmodule

// File: rtl/glitch_sched.sv
// rtl/glitch_sched.sv - trigger-driven scheduler for the glitch clock-select line
module glitch_sched
  import glitch_sched_pkg::*;
#(
  parameter int N_TRIG = 2,
  parameter int CNT_W  = 16,
  parameter int REP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [N_TRIG-1:0] trig_mask_i,
  input  logic [CNT_W-1:0]  delay_i,
  input  logic [CNT_W-1:0]  width_i,
  input  logic [CNT_W-1:0]  gap_i,
  input  logic [REP_W-1:0]  count_i,
  input  logic [N_TRIG-1:0] trig_i,
  output logic              clk_sel_o,
  output logic              armed_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [REP_W-1:0]  pulses_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(ZERO_SUB);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(ZERO_SUB);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  delay_q, width_q, gap_q;
  logic [REP_W-1:0]  count_q;
  logic [REP_W-1:0]  pulses_q, pulses_d, pulses_inc;
  logic              clk_sel_q, clk_sel_d;
  logic              done_q, done_d;
  logic              load_cfg;
  logic              rise;

  trig_sync_edge #(
    .N_TRIG (N_TRIG)
  ) u_trig (
    .clk  (clk),
    .rst_n(rst_n),
    .trig (trig_i),
    .mask (trig_mask_i),
    .rise (rise)
  );

  assign pulses_inc = pulses_q + REP_ONE;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pulses_d  = pulses_q;
    clk_sel_d = clk_sel_q;
    done_d    = 1'b0;
    load_cfg  = 1'b0;
    if (abort_i) begin
      state_d   = ST_IDLE;
      clk_sel_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (arm_i) begin
            load_cfg = 1'b1;
            pulses_d = '0;
            state_d  = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (rise) begin
            if (delay_q == '0) begin
              state_d   = ST_PULSE;
              clk_sel_d = 1'b1;
              cnt_d     = width_q;
            end else begin
              state_d = ST_DELAY;
              cnt_d   = delay_q;
            end
          end
        end
        ST_DELAY: begin
          if (cnt_q == CNT_ONE) begin
            state_d   = ST_PULSE;
            clk_sel_d = 1'b1;
            cnt_d     = width_q;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_PULSE: begin
          if (cnt_q == CNT_ONE) begin
            clk_sel_d = 1'b0;
            pulses_d  = pulses_inc;
            if (pulses_inc == count_q) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_GAP;
              cnt_d   = gap_q;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_GAP: begin
          if (cnt_q == CNT_ONE) begin
            state_d   = ST_PULSE;
            clk_sel_d = 1'b1;
            cnt_d     = width_q;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          clk_sel_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pulses_q  <= '0;
      clk_sel_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pulses_q  <= pulses_d;
      clk_sel_q <= clk_sel_d;
      done_q    <= done_d;
    end
  end

  // Delay keeps zero as a real value (immediate window); the others substitute one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay_q <= '0;
      width_q <= CNT_ONE;
      gap_q   <= CNT_ONE;
      count_q <= REP_ONE;
    end else if (load_cfg) begin
      delay_q <= delay_i;
      width_q <= (width_i == '0) ? CNT_ONE : width_i;
      gap_q   <= (gap_i == '0) ? CNT_ONE : gap_i;
      count_q <= (count_i == '0) ? REP_ONE : count_i;
    end
  end

  assign clk_sel_o = clk_sel_q;
  assign done_o    = done_q;
  assign pulses_o  = pulses_q;
  assign armed_o   = (state_q == ST_ARMED);
  assign busy_o    = (state_q == ST_DELAY) || (state_q == ST_PULSE) || (state_q == ST_GAP);

endmodule

// File: tb/tb_glitch_sched.sv
// tb/tb_glitch_sched.sv - self-checking bench for glitch_sched against a window-timing model
module tb_glitch_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  mask = 2'b00;
  logic [15:0] delay = '0;
  logic [15:0] width = '0;
  logic [15:0] gap = '0;
  logic [7:0]  count = '0;
  logic [1:0]  trig = 2'b00;
  logic        clk_sel, armed, busy, done;
  logic [7:0]  pulses;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  glitch_sched #(.N_TRIG(2), .CNT_W(16), .REP_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm_i      (arm),
    .abort_i    (abort),
    .trig_mask_i(mask),
    .delay_i    (delay),
    .width_i    (width),
    .gap_i      (gap),
    .count_i    (count),
    .trig_i     (trig),
    .clk_sel_o  (clk_sel),
    .armed_o    (armed),
    .busy_o     (busy),
    .done_o     (done),
    .pulses_o   (pulses)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed %0d required %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  // Window i rises at edge k+2+d+i*(w+g) and falls w edges later; every output follows from that.
  task automatic expect_burst(input int k, input int d, input int w, input int g, input int c,
                              input int stop);
    int we, ge, ce, last, e, r, exp_sel, exp_pul;
    we = eff(w);
    ge = eff(g);
    ce = eff(c);
    last = k + 2 + d + (ce - 1) * (we + ge) + we;
    while (cyc < last + 1 && cyc < stop) begin
      step();
      e = cyc;
      exp_sel = 0;
      exp_pul = 0;
      for (int i = 0; i < ce; i++) begin
        r = k + 2 + d + i * (we + ge);
        if (e >= r && e < r + we) exp_sel = 1;
        if (e >= r + we) exp_pul++;
      end
      chk("clk_sel", clk_sel, exp_sel);
      chk("pulses", pulses, exp_pul);
      chk("done", done, (e == last) ? 1 : 0);
      chk("busy", busy, (e >= k + 2 && e < last) ? 1 : 0);
      chk("armed", armed, (e < k + 2) ? 1 : 0);
    end
  endtask

  task automatic do_arm(input int d, input int w, input int g, input int c, input logic [1:0] m);
    delay = 16'(d);
    width = 16'(w);
    gap   = 16'(g);
    count = 8'(c);
    mask  = m;
    arm   = 1'b1;
    step();
    arm = 1'b0;
    chk("arm_armed", armed, 1);
    chk("arm_pulses", pulses, 0);
    chk("arm_busy", busy, 0);
    delay = 16'($urandom);
    width = 16'($urandom);
    gap   = 16'($urandom);
    count = 8'($urandom);
  endtask

  task automatic wait_armed(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("wait_armed", armed, 1);
      chk("wait_sel", clk_sel, 0);
    end
  endtask

  task automatic fire(input int b, input int d, input int w, input int g, input int c);
    trig[b] = 1'b1;
    expect_burst(cyc + 1, d, w, g, c, 1 << 30);
    trig = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_sel", clk_sel, 0);
      chk("idle_busy", busy, 0);
      chk("idle_armed", armed, 0);
    end
  endtask

  initial begin
    int k, r1, b, d, w, g, c;
    logic [1:0] m;

    step();
    step();
    chk("rst_sel", clk_sel, 0);
    chk("rst_armed", armed, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pulses", pulses, 0);
    rst_n = 1'b1;
    step();

    do_arm(5, 3, 2, 1, 2'b01);
    wait_armed(4);
    fire(0, 5, 3, 2, 1);

    do_arm(0, 2, 4, 3, 2'b01);
    fire(0, 0, 2, 4, 3);

    do_arm(2, 2, 2, 1, 2'b01);
    trig[1] = 1'b1;
    wait_armed(6);
    trig[1] = 1'b0;
    wait_armed(2);
    fire(0, 2, 2, 2, 1);

    trig[0] = 1'b1;
    step();
    step();
    step();
    do_arm(1, 2, 1, 2, 2'b01);
    wait_armed(5);
    trig[0] = 1'b0;
    wait_armed(3);
    fire(0, 1, 2, 1, 2);

    do_arm(2, 3, 2, 4, 2'b01);
    trig[0] = 1'b1;
    k = cyc + 1;
    r1 = k + 2 + 2 + 3 + 2;
    expect_burst(k, 2, 3, 2, 4, r1);
    chk("abort_pre_sel", clk_sel, 1);
    abort = 1'b1;
    arm = 1'b1;
    step();
    abort = 1'b0;
    arm = 1'b0;
    chk("abort_sel", clk_sel, 0);
    chk("abort_done", done, 0);
    chk("abort_pulses", pulses, 1);
    chk("abort_armed", armed, 0);
    chk("abort_busy", busy, 0);
    step();
    chk("abort_done2", done, 0);
    chk("abort_armed2", armed, 0);
    trig = 2'b00;
    step();
    step();

    abort = 1'b1;
    arm = 1'b1;
    step();
    abort = 1'b0;
    arm = 1'b0;
    chk("abort_arm_idle", armed, 0);

    do_arm(0, 0, 0, 0, 2'b01);
    fire(0, 0, 0, 0, 0);

    do_arm(3, 4, 1, 2, 2'b01);
    trig[0] = 1'b1;
    k = cyc + 1;
    expect_burst(k, 3, 4, 1, 2, k + 5);
    chk("rst_pre_sel", clk_sel, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sel", clk_sel, 0);
    chk("arst_busy", busy, 0);
    chk("arst_pulses", pulses, 0);
    chk("arst_armed", armed, 0);
    chk("arst_done", done, 0);
    #1;
    rst_n = 1'b1;
    trig = 2'b00;
    step();
    step();
    step();
    do_arm(1, 1, 1, 1, 2'b01);
    fire(0, 1, 1, 1, 1);

    for (int it = 0; it < 12; it++) begin
      d = $urandom_range(0, 6);
      w = $urandom_range(0, 4);
      g = $urandom_range(0, 4);
      c = $urandom_range(0, 4);
      b = $urandom_range(0, 1);
      m = 2'($urandom_range(0, 3)) | (2'b01 << b);
      do_arm(d, w, g, c, m);
      wait_armed($urandom_range(0, 4));
      fire(b, d, w, g, c);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
